// File: rtl/magic_seq.sv
// Streams in a 3x3 grid of digits and checks it for the magic-square property.
// One shared 3-input adder sums one line per cycle, and a registered compare stage follows the adder.
module magic_seq (
   input  logic       clock,
   input  logic       reset_L,
   input  logic       in_valid,
   input  logic [3:0] digit_in,
   output logic       in_ready,
   input  logic       clear,
   output logic       result_valid,
   input  logic       result_ack,
   output logic       is_magic,
   output logic       unique_ok,
   output logic [4:0] magic_constant,
   output logic [3:0] bad_line
);

   typedef enum logic [1:0] {S_LOAD, S_CHECK, S_DONE} state_e;

   localparam logic [3:0] NO_BAD = 4'hF;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [8:0]  seen_q;
   logic [2:0]  line_q;
   logic [3:0]  cell_q [9];
   logic [4:0]  sum_q;
   logic [2:0]  sum_idx_q;
   logic        sum_vld_q;
   logic        unique_q;
   logic [3:0]  bad_line_q;
   logic [4:0]  magic_q;
   logic        is_magic_q;
   logic        result_valid_q;
   logic        in_ready_q;

   logic [3:0]  idx_a, idx_b, idx_c;
   logic [5:0]  raw_sum;
   logic [4:0]  line_sum;
   logic [3:0]  digit_idx;
   logic [8:0]  digit_mask;
   logic        digit_bad;
   logic        seen_hit;
   logic        mismatch;
   logic        last_cmp;
   logic [3:0]  bad_line_d;

   // Cell triplet for the line currently being summed: rows, columns, then both diagonals.
   always_comb begin
      idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6;
      case (line_q)
         3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
         3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
         3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
         3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
         3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
         3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
         3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
         default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
      endcase
   end

   assign raw_sum  = {2'b00, cell_q[idx_a]} + {2'b00, cell_q[idx_b]} + {2'b00, cell_q[idx_c]};
   assign line_sum = (raw_sum > 6'd31) ? 5'd31 : raw_sum[4:0];

   assign digit_bad  = (digit_in == 4'd0) || (digit_in > 4'd9);
   assign digit_idx  = digit_in - 4'd1;
   assign digit_mask = 9'd1 << digit_idx;
   assign seen_hit   = |(seen_q & digit_mask);

   assign mismatch   = sum_vld_q && (sum_idx_q != 3'd0) && (sum_q != magic_q);
   assign bad_line_d = (mismatch && bad_line_q == NO_BAD) ? {1'b0, sum_idx_q} : bad_line_q;
   assign last_cmp   = sum_vld_q && (sum_idx_q == 3'd7);

   // NOTE: the grid storage is plain data qualified by cnt_q, so it is left out of the reset.
   always_ff @(posedge clock) begin
      if (state_q == S_LOAD && in_valid && !clear) begin
         cell_q[cnt_q] <= digit_in;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q        <= S_LOAD;
         cnt_q          <= 4'd0;
         seen_q         <= 9'd0;
         line_q         <= 3'd0;
         sum_q          <= 5'd0;
         sum_idx_q      <= 3'd0;
         sum_vld_q      <= 1'b0;
         unique_q       <= 1'b1;
         bad_line_q     <= NO_BAD;
         magic_q        <= 5'd0;
         is_magic_q     <= 1'b0;
         result_valid_q <= 1'b0;
         in_ready_q     <= 1'b1;
      end else if (clear) begin
         state_q        <= S_LOAD;
         cnt_q          <= 4'd0;
         seen_q         <= 9'd0;
         line_q         <= 3'd0;
         sum_vld_q      <= 1'b0;
         unique_q       <= 1'b1;
         bad_line_q     <= NO_BAD;
         is_magic_q     <= 1'b0;
         result_valid_q <= 1'b0;
         in_ready_q     <= 1'b1;
      end else begin
         if (sum_vld_q) begin
            if (sum_idx_q == 3'd0) magic_q <= sum_q;
            bad_line_q <= bad_line_d;
         end
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  if (digit_bad || seen_hit) unique_q <= 1'b0;
                  else                       seen_q   <= seen_q | digit_mask;
                  if (cnt_q == 4'd8) begin
                     cnt_q      <= 4'd0;
                     line_q     <= 3'd0;
                     state_q    <= S_CHECK;
                     in_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            S_CHECK: begin
               sum_q     <= line_sum;
               sum_idx_q <= line_q;
               sum_vld_q <= 1'b1;
               line_q    <= line_q + 3'd1;
               if (line_q == 3'd7) state_q <= S_DONE;
            end
            default: begin
               // First DONE cycle still drains line 7 from the compare stage; the ack is honoured only once the result is up.
               sum_vld_q <= 1'b0;
               if (last_cmp) begin
                  result_valid_q <= 1'b1;
                  is_magic_q     <= unique_q && (bad_line_d == NO_BAD);
               end
               if (result_valid_q && result_ack) begin
                  state_q        <= S_LOAD;
                  cnt_q          <= 4'd0;
                  seen_q         <= 9'd0;
                  unique_q       <= 1'b1;
                  bad_line_q     <= NO_BAD;
                  is_magic_q     <= 1'b0;
                  result_valid_q <= 1'b0;
                  in_ready_q     <= 1'b1;
               end
            end
         endcase
      end
   end

   assign in_ready       = in_ready_q;
   assign result_valid   = result_valid_q;
   assign is_magic       = is_magic_q;
   assign unique_ok      = unique_q;
   assign magic_constant = magic_q;
   assign bad_line       = bad_line_q;

endmodule

// File: tb/tb_magic_seq.sv
// Bench for magic_seq: a transaction-level model graded from whole grids, a per-cycle compare
// process, and directed grids whose results are also written out by hand.
module tb_magic_seq;

   logic       clock = 1'b0;
   logic       reset_L = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       clear = 1'b0;
   logic       result_ack = 1'b0;
   logic       in_ready, result_valid, is_magic, unique_ok;
   logic [4:0] magic_constant;
   logic [3:0] bad_line;

   int checks = 0;
   int errors = 0;

   magic_seq dut (
      .clock          (clock),
      .reset_L        (reset_L),
      .in_valid       (in_valid),
      .digit_in       (digit_in),
      .in_ready       (in_ready),
      .clear          (clear),
      .result_valid   (result_valid),
      .result_ack     (result_ack),
      .is_magic       (is_magic),
      .unique_ok      (unique_ok),
      .magic_constant (magic_constant),
      .bad_line       (bad_line)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       mag;
      logic       uniq;
      logic [4:0] mc;
      logic [3:0] bl;
   } res_t;

   localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   // Grades a complete grid directly from the magic-square rules.
   function automatic res_t grade(input int g [9]);
      res_t r;
      int   s [8];
      r.uniq = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (g[i] < 1 || g[i] > 9) r.uniq = 1'b0;
         for (int j = 0; j < i; j++) if (g[j] == g[i]) r.uniq = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
         s[k] = g[LINES[k][0]] + g[LINES[k][1]] + g[LINES[k][2]];
         if (s[k] > 31) s[k] = 31;
      end
      r.mc = 5'(s[0]);
      r.bl = 4'hF;
      for (int k = 1; k < 8; k++) if (s[k] != s[0] && r.bl == 4'hF) r.bl = 4'(k);
      r.mag = r.uniq && (r.bl == 4'hF);
      return r;
   endfunction

   // Model: phase 0 = loading, 1 = busy, 2 = result held.
   int   m_phase = 0;
   int   m_cnt = 0;
   int   m_timer = 0;
   int   m_grid [9];
   logic m_rv = 1'b0;
   res_t m_res;
   bit   cmp_en = 1'b0;

   always @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         m_phase <= 0; m_cnt <= 0; m_rv <= 1'b0;
      end else if (clear) begin
         m_phase <= 0; m_cnt <= 0; m_rv <= 1'b0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  m_grid[m_cnt] <= int'(digit_in);
                  if (m_cnt == 8) begin
                     m_phase <= 1; m_timer <= 9; m_cnt <= 0;
                  end else begin
                     m_cnt <= m_cnt + 1;
                  end
               end
            1: begin
                  m_timer <= m_timer - 1;
                  if (m_timer == 1) begin
                     m_phase <= 2; m_rv <= 1'b1; m_res <= grade(m_grid);
                  end
               end
            default: if (result_ack) begin
                  m_phase <= 0; m_rv <= 1'b0;
               end
         endcase
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("cyc.in_ready", in_ready, m_phase == 0);
         check("cyc.result_valid", result_valid, m_rv);
         if (m_rv) begin
            check("cyc.is_magic", is_magic, m_res.mag);
            check("cyc.unique_ok", unique_ok, m_res.uniq);
            check("cyc.magic_constant", magic_constant, m_res.mc);
            check("cyc.bad_line", bad_line, m_res.bl);
         end
      end
   end

   int g_magic1 [9] = '{2,7,6,9,5,1,4,3,8};
   int g_magic2 [9] = '{6,1,8,7,5,3,2,9,4};
   int g_dup    [9] = '{1,1,2,5,2,7,8,2,9};
   int g_hold   [9] = '{9,2,4,6,1,7,3,7,9};
   int g_zero   [9] = '{0,0,0,0,0,0,0,0,0};
   int g_sat    [9] = '{15,15,15,9,9,9,1,2,3};

   task automatic send(input int d, input int gap);
      repeat (gap) @(negedge clock);
      in_valid = 1'b1;
      digit_in = 4'(d);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic load(input int g [9], input int gap);
      for (int i = 0; i < 9; i++) send(g[i], gap);
   endtask

   // Cycles from the 9th accept to result_valid; -1 if it never rises.
   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clock);
         if (result_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic ack(input bit with_digit);
      result_ack = 1'b1;
      if (with_digit) begin
         in_valid = 1'b1;
         digit_in = 4'd5;
      end
      @(negedge clock);
      result_ack = 1'b0;
      in_valid   = 1'b0;
      check("ack.in_ready", in_ready, 1);
      check("ack.result_valid", result_valid, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".in_ready"}, in_ready, 1);
      check({tag, ".result_valid"}, result_valid, 0);
      check({tag, ".is_magic"}, is_magic, 0);
      check({tag, ".unique_ok"}, unique_ok, 1);
      check({tag, ".magic_constant"}, magic_constant, 0);
      check({tag, ".bad_line"}, bad_line, 4'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      repeat (2) @(negedge clock);
      check_reset_values("reset");
      cmp_en  = 1'b1;
      reset_L = 1'b1;
      @(negedge clock);

      // Back-to-back magic square, then ack with a digit offered in the same cycle.
      load(g_magic1, 0);
      wait_result(lat);
      check("m1.latency", lat, 9);
      check("m1.is_magic", is_magic, 1);
      check("m1.unique_ok", unique_ok, 1);
      check("m1.magic_constant", magic_constant, 15);
      check("m1.bad_line", bad_line, 4'hF);
      ack(1'b1);

      // Second magic square with idle gaps; result_ack held high while loading is ignored.
      result_ack = 1'b1;
      load(g_magic2, 2);
      result_ack = 1'b0;
      wait_result(lat);
      check("m2.latency", lat, 9);
      check("m2.is_magic", is_magic, 1);
      check("m2.magic_constant", magic_constant, 15);
      check("m2.bad_line", bad_line, 4'hF);
      ack(1'b0);

      load(g_dup, 0);
      wait_result(lat);
      check("dup.unique_ok", unique_ok, 0);
      check("dup.is_magic", is_magic, 0);
      check("dup.magic_constant", magic_constant, 4);
      check("dup.bad_line", bad_line, 1);
      ack(1'b0);

      // Result held without ack for five cycles.
      load(g_hold, 1);
      wait_result(lat);
      check("hold.rise", lat > 0, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold.in_ready", in_ready, 0);
         check("hold.result_valid", result_valid, 1);
         check("hold.unique_ok", unique_ok, 0);
         check("hold.magic_constant", magic_constant, 15);
         check("hold.bad_line", bad_line, 1);
         @(negedge clock);
      end
      ack(1'b0);

      load(g_zero, 0);
      wait_result(lat);
      check("zero.unique_ok", unique_ok, 0);
      check("zero.magic_constant", magic_constant, 0);
      check("zero.bad_line", bad_line, 4'hF);
      check("zero.is_magic", is_magic, 0);
      ack(1'b0);

      // Raw 4-bit digits: row 0 sum 45 saturates at 31.
      load(g_sat, 0);
      wait_result(lat);
      check("sat.magic_constant", magic_constant, 31);
      check("sat.bad_line", bad_line, 1);
      check("sat.unique_ok", unique_ok, 0);
      ack(1'b0);

      // Reset after five digits abandons the partial grid.
      for (int i = 0; i < 5; i++) send(g_dup[i], 0);
      reset_L = 1'b0;
      @(negedge clock);
      check_reset_values("midreset");
      reset_L = 1'b1;
      @(negedge clock);
      load(g_magic1, 0);
      wait_result(lat);
      check("rst.latency", lat, 9);
      check("rst.is_magic", is_magic, 1);
      ack(1'b0);

      // Clear during the third CHECK cycle, then reload.
      load(g_dup, 0);
      repeat (2) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check("clr.in_ready", in_ready, 1);
      check("clr.result_valid", result_valid, 0);
      check("clr.bad_line", bad_line, 4'hF);
      check("clr.unique_ok", unique_ok, 1);
      load(g_magic1, 0);
      wait_result(lat);
      check("clr.latency", lat, 9);
      check("clr.is_magic", is_magic, 1);
      check("clr.magic_constant", magic_constant, 15);
      ack(1'b0);

      repeat (2) @(negedge clock);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
